// File: rtl/ucie_mbtrain_pkg.sv
// Shared MBTRAIN definitions: eye-width sweep state encoding and parameter defaults.
package ucie_mbtrain_pkg;

  localparam int NUM_LANES_DEF  = 16;
  localparam int PI_W_DEF       = 4;
  localparam int PI_MAX_DEF     = 15;
  localparam int SETTLE_CYC_DEF = 4;
  localparam int MIN_EYE_DEF    = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_APPLY  = 3'd2,
    ST_RUN    = 3'd3,
    ST_UPDATE = 3'd4,
    ST_DONE   = 3'd5
  } sweep_state_e;

endpackage

// File: rtl/eye_width_sweep_if.sv
// Handshake bundle between the centre-cal sequencer / point tester (master) and the sweep (slave).
interface eye_width_sweep_if #(
  parameter int NUM_LANES = 16,
  parameter int PI_W      = 4
);
  logic                 i_en;
  logic                 i_mainband_or_valtrain_test;
  logic                 o_pt_en;
  logic                 i_pt_done;
  logic [NUM_LANES-1:0] i_pt_lanes_result;
  logic [PI_W-1:0]      o_pi_step;
  logic [NUM_LANES-1:0] o_tx_lanes_result;
  logic [PI_W-1:0]      o_center_step;
  logic                 o_test_ack;

  modport master (
    output i_en, i_mainband_or_valtrain_test, i_pt_done, i_pt_lanes_result,
    input  o_pt_en, o_pi_step, o_tx_lanes_result, o_center_step, o_test_ack
  );

  modport slave (
    input  i_en, i_mainband_or_valtrain_test, i_pt_done, i_pt_lanes_result,
    output o_pt_en, o_pi_step, o_tx_lanes_result, o_center_step, o_test_ack
  );
endinterface

// File: rtl/lane_window_tracker.sv
// Longest-passing-window tracker for one pass bit: current run, best run and the PI code where it ended.
module lane_window_tracker
  import ucie_mbtrain_pkg::*;
#(
  parameter int PI_W   = PI_W_DEF,
  parameter int PI_MAX = PI_MAX_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_clr,
  input  logic            i_upd,
  input  logic            i_pass,
  input  logic [PI_W-1:0] i_pi,
  output logic [PI_W:0]   o_best_run,
  output logic [PI_W-1:0] o_best_end
);

  localparam logic [PI_W:0] RUN_SAT = (PI_W + 1)'(PI_MAX + 1);
  localparam logic [PI_W:0] RUN_ONE = (PI_W + 1)'(1);

  logic [PI_W:0]   cur_run_q, cur_run_d;
  logic [PI_W:0]   best_run_q, best_run_d;
  logic [PI_W:0]   run_inc;
  logic [PI_W-1:0] best_end_q, best_end_d;

  // Strictly-greater update keeps the earliest of several equal-length windows.
  always_comb begin
    cur_run_d  = cur_run_q;
    best_run_d = best_run_q;
    best_end_d = best_end_q;
    if (cur_run_q == RUN_SAT) begin
      run_inc = cur_run_q;
    end else begin
      run_inc = cur_run_q + RUN_ONE;
    end
    if (i_clr) begin
      cur_run_d  = '0;
      best_run_d = '0;
      best_end_d = '0;
    end else if (i_upd) begin
      if (i_pass) begin
        cur_run_d = run_inc;
      end else begin
        cur_run_d = '0;
      end
      if (cur_run_d > best_run_q) begin
        best_run_d = cur_run_d;
        best_end_d = i_pi;
      end else begin
        best_run_d = best_run_q;
        best_end_d = best_end_q;
      end
    end else begin
      cur_run_d  = cur_run_q;
      best_run_d = best_run_q;
      best_end_d = best_end_q;
    end
  end

  // Tracker state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_run_q  <= '0;
      best_run_q <= '0;
      best_end_q <= '0;
    end else begin
      cur_run_q  <= cur_run_d;
      best_run_q <= best_run_d;
      best_end_q <= best_end_d;
    end
  end

  assign o_best_run = best_run_q;
  assign o_best_end = best_end_q;

endmodule

// File: rtl/eye_width_sweep.sv
// PI phase sweep after centre-cal: per-code point tests, per-lane and aggregate eye windows, centre report.
// Optional EYE_SWEEP_EARLY_EXIT_EN closes the sweep once the aggregate eye has opened and then failed.
module eye_width_sweep
  import ucie_mbtrain_pkg::*;
#(
  parameter int NUM_LANES  = NUM_LANES_DEF,
  parameter int PI_W       = PI_W_DEF,
  parameter int PI_MAX     = PI_MAX_DEF,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF,
  parameter int MIN_EYE    = MIN_EYE_DEF
) (
  input logic             clk,
  input logic             rst_n,
  eye_width_sweep_if.slave bus
);

  localparam int                   SET_W       = $clog2(SETTLE_CYC + 1);
  localparam logic [SET_W-1:0]     SETTLE_LAST = SET_W'(SETTLE_CYC);
  localparam logic [SET_W-1:0]     SET_ONE     = SET_W'(1);
  localparam logic [PI_W-1:0]      PI_LAST     = PI_W'(PI_MAX);
  localparam logic [PI_W-1:0]      PI_ONE      = PI_W'(1);
  localparam logic [PI_W:0]        RUN_ONE     = (PI_W + 1)'(1);
  localparam logic [PI_W:0]        MIN_EYE_W   = (PI_W + 1)'(MIN_EYE);
  localparam logic [NUM_LANES-1:0] LANE0_MASK  = {{(NUM_LANES - 1){1'b0}}, 1'b1};

  sweep_state_e         state_q, state_d;
  logic [PI_W-1:0]      pi_q, pi_d;
  logic [SET_W-1:0]     settle_q, settle_d;
  logic                 vt_q, vt_d;
  logic [NUM_LANES-1:0] res_q, res_d;
  logic                 pt_en_q, pt_en_d;
  logic                 ack_q, ack_d;
  logic [NUM_LANES-1:0] lanes_q, lanes_d;
  logic [PI_W-1:0]      center_q, center_d;
  logic [PI_W-1:0]      pi_out_q, pi_out_d;

  logic [NUM_LANES-1:0] lane_mask_s;
  logic [NUM_LANES-1:0] lane_ok_s;
  logic [NUM_LANES:0]   trk_pass_s;
  logic                 agg_pass_s;
  logic                 trk_clr_s;
  logic                 trk_upd_s;
  logic                 early_exit_s;
  logic [PI_W-1:0]      centre_s;
  logic [PI_W:0]        best_run [0:NUM_LANES];
  logic [PI_W-1:0]      agg_best_end;
  logic [PI_W-1:0]      lane_end_unused [0:NUM_LANES-1];

  // Midpoint of a window ending at bend; the subtraction cannot underflow since run-1 <= bend.
  function automatic logic [PI_W-1:0] centre_of(input logic [PI_W:0] run, input logic [PI_W-1:0] bend);
    logic [PI_W:0] half;
    logic [PI_W:0] wide;
    half = (run - RUN_ONE) >> 1;
    wide = {1'b0, bend} - half;
    if (run == '0) begin
      centre_of = '0;
    end else begin
      centre_of = wide[PI_W-1:0];
    end
  endfunction

  // Active-lane mask, masked pass vector and per-lane verdicts.
  always_comb begin
    if (vt_q) begin
      lane_mask_s = LANE0_MASK;
    end else begin
      lane_mask_s = '1;
    end
    agg_pass_s = &(res_q | ~lane_mask_s);
    trk_pass_s = {agg_pass_s, res_q & lane_mask_s};
    lane_ok_s  = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      lane_ok_s[l] = (best_run[l] >= MIN_EYE_W) & lane_mask_s[l];
    end
    centre_s = centre_of(best_run[NUM_LANES], agg_best_end);
  end

  assign trk_clr_s = (state_q == ST_SETUP);
  assign trk_upd_s = (state_q == ST_UPDATE) & bus.i_en;

`ifdef EYE_SWEEP_EARLY_EXIT_EN
  // A failing code after the aggregate eye already reached MIN_EYE cannot grow that window further.
  assign early_exit_s = (best_run[NUM_LANES] >= MIN_EYE_W) & ~agg_pass_s;
`else
  assign early_exit_s = 1'b0;
`endif

  for (genvar g = 0; g <= NUM_LANES; g++) begin : g_trk
    if (g < NUM_LANES) begin : g_lane
      lane_window_tracker #(.PI_W(PI_W), .PI_MAX(PI_MAX)) u_trk (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (trk_clr_s),
        .i_upd      (trk_upd_s),
        .i_pass     (trk_pass_s[g]),
        .i_pi       (pi_q),
        .o_best_run (best_run[g]),
        .o_best_end (lane_end_unused[g])
      );
    end else begin : g_agg
      lane_window_tracker #(.PI_W(PI_W), .PI_MAX(PI_MAX)) u_trk (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (trk_clr_s),
        .i_upd      (trk_upd_s),
        .i_pass     (trk_pass_s[g]),
        .i_pi       (pi_q),
        .o_best_run (best_run[g]),
        .o_best_end (agg_best_end)
      );
    end
  end

  // Next-state and next-output logic; dropping i_en aborts from any state.
  always_comb begin
    state_d  = state_q;
    pi_d     = pi_q;
    settle_d = settle_q;
    vt_d     = vt_q;
    res_d    = res_q;
    pt_en_d  = 1'b0;
    ack_d    = 1'b0;
    lanes_d  = '0;
    center_d = '0;
    if (!bus.i_en) begin
      state_d  = ST_IDLE;
      pi_d     = '0;
      settle_d = '0;
      res_d    = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_SETUP;
        end
        ST_SETUP: begin
          pi_d     = '0;
          settle_d = '0;
          vt_d     = bus.i_mainband_or_valtrain_test;
          state_d  = ST_APPLY;
        end
        ST_APPLY: begin
          if (settle_q == SETTLE_LAST) begin
            settle_d = '0;
            pt_en_d  = 1'b1;
            state_d  = ST_RUN;
          end else begin
            settle_d = settle_q + SET_ONE;
          end
        end
        ST_RUN: begin
          if (bus.i_pt_done) begin
            res_d   = bus.i_pt_lanes_result;
            state_d = ST_UPDATE;
          end else begin
            pt_en_d = 1'b1;
          end
        end
        ST_UPDATE: begin
          if ((pi_q == PI_LAST) || early_exit_s) begin
            state_d = ST_DONE;
          end else begin
            pi_d    = pi_q + PI_ONE;
            state_d = ST_APPLY;
          end
        end
        ST_DONE: begin
          ack_d    = 1'b1;
          lanes_d  = lane_ok_s;
          center_d = centre_s;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    // Trackers settle one cycle after entering DONE, so the centre appears together with ack.
    if (state_d == ST_IDLE) begin
      pi_out_d = '0;
    end else if (state_q == ST_DONE) begin
      pi_out_d = centre_s;
    end else begin
      pi_out_d = pi_d;
    end
  end

  // Sweep FSM state and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      pi_q     <= '0;
      settle_q <= '0;
      vt_q     <= 1'b0;
      res_q    <= '0;
      pt_en_q  <= 1'b0;
      ack_q    <= 1'b0;
      lanes_q  <= '0;
      center_q <= '0;
      pi_out_q <= '0;
    end else begin
      state_q  <= state_d;
      pi_q     <= pi_d;
      settle_q <= settle_d;
      vt_q     <= vt_d;
      res_q    <= res_d;
      pt_en_q  <= pt_en_d;
      ack_q    <= ack_d;
      lanes_q  <= lanes_d;
      center_q <= center_d;
      pi_out_q <= pi_out_d;
    end
  end

  assign bus.o_pt_en           = pt_en_q;
  assign bus.o_test_ack        = ack_q;
  assign bus.o_tx_lanes_result = lanes_q;
  assign bus.o_center_step     = center_q;
  assign bus.o_pi_step         = pi_out_q;

endmodule

// File: tb/tb_eye_width_sweep.sv
// Bench for eye_width_sweep: directed and random pass maps checked against a window-scan reference model.
module tb_eye_width_sweep;
  import ucie_mbtrain_pkg::*;

  localparam int NL = 16;
  localparam int PW = 4;
  localparam int PM = 15;
  localparam int SC = 4;
  localparam int ME = 4;
`ifdef EYE_SWEEP_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;
  logic [NL-1:0] pat [0:PM];

  always #5 clk = ~clk;

  eye_width_sweep_if #(.NUM_LANES(NL), .PI_W(PW)) bus ();

  eye_width_sweep #(.NUM_LANES(NL), .PI_W(PW), .PI_MAX(PM), .SETTLE_CYC(SC), .MIN_EYE(ME)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pass bit of one lane (lane >= 0) or of the aggregate (lane < 0) at code c.
  function automatic bit bit_at(input int lane, input int c, input bit vt);
    if (lane >= 0) return pat[c][lane];
    else if (vt) return pat[c][0];
    else return &pat[c];
  endfunction

  // Longest run of passing codes in 0..n-1; the earliest wins on ties.
  function automatic int best_win(input int lane, input int n, input bit vt, output int bend);
    int best, len;
    best = 0;
    bend = 0;
    for (int s = 0; s < n; s++) begin
      len = 0;
      while ((s + len < n) && bit_at(lane, s + len, vt)) len++;
      if (len > best) begin
        best = len;
        bend = s + len - 1;
      end
    end
    return best;
  endfunction

  function automatic int sweep_len(input bit vt);
    int e;
    for (int c = 0; c <= PM; c++) begin
      if (EARLY_EXIT && (best_win(-1, c, vt, e) >= ME) && !bit_at(-1, c, vt)) return c + 1;
    end
    return PM + 1;
  endfunction

  task automatic fill(input int lo, input int hi);
    for (int c = 0; c <= PM; c++) pat[c] = ((c >= lo) && (c <= hi)) ? {NL{1'b1}} : {NL{1'b0}};
  endtask

  task automatic rand_pattern();
    int lo, len;
    for (int l = 0; l < NL; l++) begin
      lo  = $urandom_range(0, PM);
      len = $urandom_range(0, 10);
      for (int c = 0; c <= PM; c++) pat[c][l] = (c >= lo) && (c < lo + len);
    end
    if ($urandom_range(0, 1) == 1) begin
      lo  = $urandom_range(0, PM);
      len = $urandom_range(1, 9);
      for (int c = lo; (c < lo + len) && (c <= PM); c++) pat[c] = {NL{1'b1}};
    end
    for (int c = 0; c <= PM; c++) begin
      if ($urandom_range(0, 5) == 0) pat[c][$urandom_range(0, NL - 1)] ^= 1'b1;
    end
  endtask

  // Serve one point test; st = 0 served, 1 ack seen, 2 timed out.
  task automatic serve_one(input int code, input bit noisy, output int st);
    int k;
    k = 0;
    while (!bus.o_pt_en && !bus.o_test_ack && (k < 300)) begin
      @(negedge clk);
      k++;
    end
    if (bus.o_test_ack) begin
      st = 1;
    end else if (!bus.o_pt_en) begin
      check("pt_en_timeout", 32'd0, 32'd1);
      st = 2;
    end else begin
      check($sformatf("pi_step_c%0d", code), 32'(bus.o_pi_step), 32'(code));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      bus.i_pt_done = 1'b1;
      bus.i_pt_lanes_result = pat[code % (PM + 1)];
      @(negedge clk);
      bus.i_pt_done = 1'b0;
      bus.i_pt_lanes_result = NL'($urandom);
      check("pt_en_fall", 32'(bus.o_pt_en), 32'd0);
      if (noisy) begin
        @(negedge clk);
        bus.i_pt_done = 1'b1;
        bus.i_pt_lanes_result = ~pat[code % (PM + 1)];
        @(negedge clk);
        bus.i_pt_done = 1'b0;
        bus.i_mainband_or_valtrain_test = ~bus.i_mainband_or_valtrain_test;
      end
      st = 0;
    end
  endtask

  task automatic do_sweep(input string name, input bit vt, input bit noisy);
    int n, e, b, cnt, st, exp_ctr;
    logic [NL-1:0] exp_res;
    n = sweep_len(vt);
    exp_res = '0;
    for (int l = 0; l < NL; l++) begin
      b = best_win(l, n, vt, e);
      if (((!vt) || (l == 0)) && (b >= ME)) exp_res[l] = 1'b1;
    end
    b = best_win(-1, n, vt, e);
    exp_ctr = (b == 0) ? 0 : e - (b - 1) / 2;
    bus.i_mainband_or_valtrain_test = vt;
    bus.i_en = 1'b1;
    cnt = 0;
    st = 0;
    while ((st == 0) && (cnt < PM + 4)) begin
      serve_one(cnt, noisy, st);
      if (st == 0) cnt++;
    end
    check({name, "_ntests"}, 32'(cnt), 32'(n));
    check({name, "_ack"}, 32'(bus.o_test_ack), 32'd1);
    check({name, "_result"}, 32'(bus.o_tx_lanes_result), 32'(exp_res));
    check({name, "_centre"}, 32'(bus.o_center_step), 32'(exp_ctr));
    check({name, "_pi_done"}, 32'(bus.o_pi_step), 32'(exp_ctr));
    repeat (3) @(negedge clk);
    check({name, "_ack_hold"}, 32'(bus.o_test_ack), 32'd1);
    bus.i_en = 1'b0;
    @(negedge clk);
    check({name, "_ack_clr"}, 32'(bus.o_test_ack), 32'd0);
    check({name, "_res_clr"}, 32'(bus.o_tx_lanes_result), 32'd0);
    check({name, "_pi_clr"}, 32'(bus.o_pi_step), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    int st, k;
    rst_n = 1'b0;
    bus.i_en = 1'b0;
    bus.i_mainband_or_valtrain_test = 1'b0;
    bus.i_pt_done = 1'b0;
    bus.i_pt_lanes_result = '0;
    repeat (3) @(negedge clk);
    check("rst_pt_en", 32'(bus.o_pt_en), 32'd0);
    check("rst_ack", 32'(bus.o_test_ack), 32'd0);
    check("rst_pi", 32'(bus.o_pi_step), 32'd0);
    check("rst_res", 32'(bus.o_tx_lanes_result), 32'd0);
    check("rst_ctr", 32'(bus.o_center_step), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    fill(5, 12);
    do_sweep("mb_5_12", 1'b0, 1'b0);

    fill(4, 11);
    for (int c = 0; c <= PM; c++) pat[c][3] = (c <= 2);
    do_sweep("mb_lane3", 1'b0, 1'b0);

    for (int c = 0; c <= PM; c++) begin
      pat[c] = NL'($urandom);
      pat[c][0] = (c >= 2) && (c <= 9);
    end
    do_sweep("vt_2_9", 1'b1, 1'b1);

    fill(2, 5);
    for (int c = 9; c <= 12; c++) pat[c] = {NL{1'b1}};
    do_sweep("two_win", 1'b0, 1'b0);

    fill(0, PM);
    do_sweep("all_pass", 1'b0, 1'b1);

    rand_pattern();
    bus.i_mainband_or_valtrain_test = 1'b0;
    bus.i_en = 1'b1;
    for (int c = 0; c < 7; c++) serve_one(c, 1'b0, st);
    k = 0;
    while (!bus.o_pt_en && (k < 300)) begin
      @(negedge clk);
      k++;
    end
    check("abort_pi7", 32'(bus.o_pi_step), 32'd7);
    bus.i_en = 1'b0;
    @(negedge clk);
    check("abort_pt_en", 32'(bus.o_pt_en), 32'd0);
    check("abort_ack", 32'(bus.o_test_ack), 32'd0);
    check("abort_pi", 32'(bus.o_pi_step), 32'd0);
    bus.i_pt_done = 1'b1;
    bus.i_pt_lanes_result = {NL{1'b1}};
    @(negedge clk);
    bus.i_pt_done = 1'b0;
    repeat (4) @(negedge clk);
    check("late_done_pt_en", 32'(bus.o_pt_en), 32'd0);
    check("late_done_pi", 32'(bus.o_pi_step), 32'd0);
    check("late_done_ack", 32'(bus.o_test_ack), 32'd0);
    check("late_done_res", 32'(bus.o_tx_lanes_result), 32'd0);
    rand_pattern();
    do_sweep("restart", 1'b0, 1'b0);

    fill(3, 8);
    do_sweep("early_3_8", 1'b0, 1'b0);

    for (int r = 0; r < 8; r++) begin
      rand_pattern();
      do_sweep($sformatf("rand%0d", r), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
